// File: rtl/decode_exe_stage_pkg.sv
// Shared constants for the decode-to-execute stage: opcode/register widths,
// the load opcode and the operand forwarding select encodings.
package decode_exe_stage_pkg;

    localparam int DATA_BITS    = 32;
    localparam int REG_IDX_BITS = 4;
    localparam int OPCODE_BITS  = 4;

    localparam logic [OPCODE_BITS-1:0] LW_OPCODE = 4'b0111;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXE = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// 4:1 operand select between register-file data and the EX/MEM/WB forwarded
// results, steered by a forwarding select from the decode-stage forwarding unit.
module operand_fwd_mux
    import decode_exe_stage_pkg::*;
#(
    parameter int DBITS = DATA_BITS
) (
    input  logic [1:0]       sel,
    input  logic [DBITS-1:0] rf_data,
    input  logic [DBITS-1:0] exe_data,
    input  logic [DBITS-1:0] mem_data,
    input  logic [DBITS-1:0] wb_data,
    output logic [DBITS-1:0] data_out
);

    always_comb begin
        // NOTE: assign a default first so no select value leaves data_out unassigned (no latch).
        data_out = rf_data;
        case (fwd_sel_e'(sel))
            FWD_RF:  data_out = rf_data;
            FWD_EXE: data_out = exe_data;
            FWD_MEM: data_out = mem_data;
            FWD_WB:  data_out = wb_data;
            default: data_out = rf_data;
        endcase
    end

endmodule

// File: rtl/decode_exe_stage.sv
// ID/EX pipeline stage: operand forwarding, load-use stall/bubble insertion and
// the ID/EX register. Define PERF_CNT_EN to add stall_cnt/bubble_cnt counters.
module decode_exe_stage
    import decode_exe_stage_pkg::*;
#(
    parameter int                  DBITS     = DATA_BITS,
    parameter int                  REG_BITS  = REG_IDX_BITS,
    parameter int                  OP_BITS   = OPCODE_BITS,
    parameter logic [OP_BITS-1:0]  LW_OPCODE = decode_exe_stage_pkg::LW_OPCODE
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                dcd_valid,
    input  logic [OP_BITS-1:0]  dcd_opcode,
    input  logic [REG_BITS-1:0] dcd_rs1,
    input  logic [REG_BITS-1:0] dcd_rs2,
    input  logic [REG_BITS-1:0] dcd_rd,
    input  logic                dcd_use_rs1,
    input  logic                dcd_use_rs2,
    input  logic                dcd_wrReg,
    input  logic [DBITS-1:0]    dcd_imm,
    input  logic [DBITS-1:0]    rf_data1,
    input  logic [DBITS-1:0]    rf_data2,
    input  logic [1:0]          dcd_data1_sel,
    input  logic [1:0]          dcd_data2_sel,
    input  logic [DBITS-1:0]    exe_result,
    input  logic [DBITS-1:0]    mem_result,
    input  logic [DBITS-1:0]    wb_result,
    input  logic                flush,
    input  logic                mem_stall,
    output logic                stall,
    output logic                exe_valid,
    output logic                wrReg_EX,
    output logic [OP_BITS-1:0]  exe_opcode,
    output logic [REG_BITS-1:0] exe_rd,
    output logic [DBITS-1:0]    exe_a,
    output logic [DBITS-1:0]    exe_b,
    output logic [DBITS-1:0]    exe_imm
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         bubble_cnt
`endif
);

    logic [DBITS-1:0] op_a;
    logic [DBITS-1:0] op_b;
    logic             load_use;
    logic             bubble_load;

    operand_fwd_mux #(.DBITS(DBITS)) u_mux_a (
        .sel      (dcd_data1_sel),
        .rf_data  (rf_data1),
        .exe_data (exe_result),
        .mem_data (mem_result),
        .wb_data  (wb_result),
        .data_out (op_a)
    );

    operand_fwd_mux #(.DBITS(DBITS)) u_mux_b (
        .sel      (dcd_data2_sel),
        .rf_data  (rf_data2),
        .exe_data (exe_result),
        .mem_data (mem_result),
        .wb_data  (wb_result),
        .data_out (op_b)
    );

    // A load in EX cannot forward until it reaches MEM, so a dependent decode waits one cycle.
    assign load_use = exe_valid & wrReg_EX & (exe_opcode == LW_OPCODE) & dcd_valid &
                      ((dcd_use_rs1 & (dcd_rs1 == exe_rd)) |
                       (dcd_use_rs2 & (dcd_rs2 == exe_rd)));

    assign stall       = mem_stall | (load_use & ~flush);
    assign bubble_load = flush | load_use;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exe_valid  <= 1'b0;
            wrReg_EX   <= 1'b0;
            exe_opcode <= '0;
            exe_rd     <= '0;
            exe_a      <= '0;
            exe_b      <= '0;
            exe_imm    <= '0;
        end else if (!mem_stall) begin
            if (bubble_load) begin
                exe_valid  <= 1'b0;
                wrReg_EX   <= 1'b0;
                exe_opcode <= '0;
                exe_rd     <= '0;
                exe_a      <= '0;
                exe_b      <= '0;
                exe_imm    <= '0;
            end else begin
                exe_valid  <= dcd_valid;
                wrReg_EX   <= dcd_wrReg & dcd_valid;
                exe_opcode <= dcd_opcode;
                exe_rd     <= dcd_rd;
                exe_a      <= op_a;
                exe_b      <= op_b;
                exe_imm    <= dcd_imm;
            end
        end
    end

`ifdef PERF_CNT_EN
    // A held ID/EX register (mem_stall) loads nothing, so it never counts as a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (!mem_stall && bubble_load && dcd_valid) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/decode_exe_stage.md
# decode_exe_stage

Decode-to-execute pipeline stage of the pipelined processor. Consumes the forwarding selects produced by the decode-stage forwarding unit and builds the two execute operands from register-file data or the forwarded EX/MEM/WB results. Detects load-use hazards, stalls decode and inserts bubbles, and holds the ID/EX pipeline register that drives the execute stage, including `wrReg_EX`/`exe_rd` fed back to the forwarding unit.

## Interface
Parameters:
- DBITS, 32, datapath width
- REG_BITS, 4, register index width
- OP_BITS, 4, opcode width
- LW_OPCODE, 4'b0111, opcode of the load instruction

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  stage clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- dcd_valid  in  1  decode holds a valid instruction
- dcd_opcode  in  OP_BITS  decoded opcode
- dcd_rs1, dcd_rs2, dcd_rd  in  REG_BITS each  source and destination indices
- dcd_use_rs1, dcd_use_rs2  in  1 each  instruction actually reads rs1/rs2
- dcd_wrReg  in  1  instruction writes rd
- dcd_imm  in  DBITS  sign-extended immediate
- rf_data1, rf_data2  in  DBITS each  register-file read data
- dcd_data1_sel, dcd_data2_sel  in  2 each  0 regfile, 1 exe, 2 mem, 3 wb
- exe_result, mem_result, wb_result  in  DBITS each  forwarded values
- flush  in  1  branch redirect; squash decode instruction
- mem_stall  in  1  downstream hold request
- stall  out  1  freeze fetch/decode this cycle
- exe_valid, wrReg_EX  out  1 each  ID/EX valid and write enable
- exe_opcode  out  OP_BITS; exe_rd  out  REG_BITS
- exe_a, exe_b, exe_imm  out  DBITS each  execute operands
- stall_cnt, bubble_cnt  out  32 each  only with PERF_CNT_EN

## Operation
- Operand mux: opA = sel1 {0: rf_data1, 1: exe_result, 2: mem_result, 3: wb_result}; opB likewise with sel2.
- Load-use hazard: `lu = exe_valid & wrReg_EX & exe_opcode==LW_OPCODE & dcd_valid & ((dcd_use_rs1 & dcd_rs1==exe_rd) | (dcd_use_rs2 & dcd_rs2==exe_rd))`.
- stall = mem_stall | (lu & ~flush). Combinational, same cycle.
- ID/EX update priority at each edge:
  1. mem_stall: hold all exe_* unchanged. This applies even with flush; flush is then re-presented by its source.
  2. flush: load a bubble (exe_valid=0, wrReg_EX=0, other fields 0).
  3. lu: load a bubble; decode is held by stall.
  4. Otherwise: exe_valid←dcd_valid, wrReg_EX←dcd_wrReg&dcd_valid, exe_opcode/rd/imm from decode, exe_a←opA, exe_b←opB.
- Bubbles never drive wrReg_EX=1, so the forwarding unit never selects a bubble.
- A stall costs exactly one cycle per load-use. On the next cycle the load is in MEM and sel=2 resolves the operand.

## Timing
- Reset (async assert, sync release on clk): exe_valid=0, wrReg_EX=0, exe_opcode=0, exe_rd=0, exe_a=exe_b=exe_imm=0, counters=0. stall follows inputs (0 with idle inputs).
- Latency: decode fields visible on exe_* 1 cycle after the edge that captures them.
- Reset asserted mid-stall: state clears immediately. The first post-reset cycle has no hazard.

## Configuration
- PERF_CNT_EN defined:
  - stall_cnt increments on each cycle with stall=1.
  - bubble_cnt increments on each edge loading a bubble due to lu or flush, with dcd_valid=1.
  - Both wrap at 2^32 and reset to 0.
- PERF_CNT_EN undefined: ports stall_cnt/bubble_cnt absent; no counter logic.

## Structure
- Shared package: LW_OPCODE, forwarding select encodings (FWD_RF, FWD_EXE, FWD_MEM, FWD_WB), opcode width constants.
- One sub-module: `operand_fwd_mux` (4:1 DBITS mux on a 2-bit select), instantiated twice.

## Test plan
- ADD r3 then SUB r4=r3-r1, sel1=1, exe_result=0x15 → next cycle exe_a=0x15, stall=0.
- LW r2 in exe (opcode 0111), decode ADD uses rs2=2 → stall=1 one cycle, bubble (exe_valid=0); next cycle sel2=2, mem_result=0xAB → exe_b=0xAB.
- LW r2 in exe, decode uses only rs1=5, dcd_use_rs2=0 with rs2=2 → stall=0, no bubble.
- Load-use and flush same cycle → stall=0, bubble inserted; with PERF_CNT_EN, bubble_cnt +1, stall_cnt unchanged.
- mem_stall=1 for 3 cycles with flush=1 → exe_* unchanged all 3 cycles, stall=1, stall_cnt +3.
- reset_n low mid-operation with exe_valid=1 → exe_valid, wrReg_EX, exe_a, and counters read 0 before the next clk edge.
